// File: rtl/seqdet_pkg.sv
// Shared types and width helpers for the serial sequence detector.
// Lane config is held at maximum width; unused upper bits are always zero.
package seqdet_pkg;

    localparam int SEQDET_PAT_MAX   = 32;
    localparam int SEQDET_LEN_MAX_W = 6;

    localparam logic [SEQDET_LEN_MAX_W-1:0] LEN_DISABLED = '0;

    typedef struct packed {
        logic [SEQDET_PAT_MAX-1:0]   pat;
        logic [SEQDET_LEN_MAX_W-1:0] len;
        logic                        ovl;
    } lane_cfg_t;

    function automatic int calc_idx_w(input int num_pat);
        return (num_pat <= 2) ? 1 : $clog2(num_pat);
    endfunction

    function automatic int calc_len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seqdet_lane.sv
// One detector lane: config registers, fill counter, masked compare, optional hit counter.
// Latency: z combinational; hit_cnt one cycle after match. Backpressure: none.
module seqdet_lane
    import seqdet_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8,
    parameter int LEN_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [PAT_W-1:0] win,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] hit_cnt
);

    lane_cfg_t                 cfg;
    logic [LEN_W-1:0]          fill;
    logic [SEQDET_PAT_MAX-1:0] win_ext;
    logic [SEQDET_PAT_MAX-1:0] mask;
    logic                      len_ok;
    logic                      fill_ok;

    always_comb begin
        win_ext = SEQDET_PAT_MAX'(win);
        mask    = '0;
        for (int b = 0; b < SEQDET_PAT_MAX; b++) begin
            mask[b] = (b < int'(cfg.len));
        end
        len_ok  = (cfg.len != LEN_DISABLED) && (int'(cfg.len) <= PAT_W);
        // The current bit w completes the pattern, so only len-1 prior bits are needed.
        fill_ok = (int'(fill) + 1 >= int'(cfg.len));
        z       = in_valid && len_ok && fill_ok && ((win_ext & mask) == (cfg.pat & mask));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg.pat <= '0;
            cfg.len <= LEN_DISABLED;
            cfg.ovl <= 1'b1;
            fill    <= '0;
        end else if (cfg_we) begin
            cfg.pat <= SEQDET_PAT_MAX'(cfg_pat);
            cfg.len <= SEQDET_LEN_MAX_W'(cfg_len);
            cfg.ovl <= cfg_ovl;
            fill    <= '0;
        end else if (in_valid) begin
            if (z && !cfg.ovl) begin
                fill <= '0;
            end else if (int'(fill) < PAT_W) begin
                fill <= fill + LEN_W'(1);
            end
        end
    end

`ifdef SEQDET_HITCNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (z && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign hit_cnt = cnt;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign hit_cnt        = '0;
`endif

endmodule

// File: rtl/seq_detector_n.sv
// Multi-lane programmable serial sequence detector; hit counters built only with SEQDET_HITCNT_EN.
// Latency: z/z_any combinational, z_q and hit_cnt one cycle later. Backpressure: none, in_valid=0 holds state.
module seq_detector_n
    import seqdet_pkg::*;
#(
    parameter int PAT_W   = 3,
    parameter int NUM_PAT = 2,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = calc_idx_w(NUM_PAT),
    localparam int LEN_W  = calc_len_w(PAT_W)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w,
    input  logic                     in_valid,
    input  logic                     cfg_we,
    input  logic [IDX_W-1:0]         cfg_idx,
    input  logic [PAT_W-1:0]         cfg_pat,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     cfg_ovl,
    input  logic                     cnt_clr,
    output logic [NUM_PAT-1:0]       z,
    output logic [NUM_PAT-1:0]       z_q,
    output logic                     z_any,
    output logic [NUM_PAT*CNT_W-1:0] hit_cnt
);

    logic [PAT_W-2:0] hist;
    logic [PAT_W-1:0] win;

    assign win   = {hist, w};
    assign z_any = |z;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            z_q  <= '0;
        end else begin
            z_q <= z;
            if (in_valid) begin
                hist <= win[PAT_W-2:0];
            end
        end
    end

    // Out-of-range cfg_idx never matches any lane, so the write is dropped.
    for (genvar i = 0; i < NUM_PAT; i++) begin : g_lane
        logic lane_we;
        assign lane_we = cfg_we && (cfg_idx == IDX_W'(i));

        seqdet_lane #(
            .PAT_W (PAT_W),
            .CNT_W (CNT_W),
            .LEN_W (LEN_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid),
            .win      (win),
            .cfg_we   (lane_we),
            .cfg_pat  (cfg_pat),
            .cfg_len  (cfg_len),
            .cfg_ovl  (cfg_ovl),
            .cnt_clr  (cnt_clr),
            .z        (z[i]),
            .hit_cnt  (hit_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule
